mmio_uart_tx: RTL

- Memory-mapped UART transmitter. It is a responder on the core's MMIO bus (addr/wr_data/rd_data/cs/wr/rd).
- Software stores bytes into an 8-deep TX FIFO. An FSM serialises them 8N1, LSB first, on uart_tx.
- Read data is returned combinationally in the same cycle, because the core samples rd_data in its memory stage.
- Multiple responders may be OR-combined onto one rd_data.

---
 rtl/mmio_uart_pkg.sv | 26 ++
 rtl/mmio_uart_tx_if.sv | 20 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/mmio_uart_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, status/control bit positions and FSM states.
package mmio_uart_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_CTRL    = 2'd2;
    localparam logic [1:0] OFF_BAUDDIV = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_LEVEL = 8;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core MMIO bus: byte address, write/read data, range select and
// single-cycle write/read strobes.
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        cs;
    logic        wr;
    logic        rd;

    modport master (
        output addr, wr_data, cs, wr, rd,
        input  rd_data
    );

    modport slave (
        input  addr, wr_data, cs, wr, rd,
        output rd_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy count.
// A push while full is only taken when a pop frees a slot that cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2, at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: register file, TX FIFO and an 8N1 serialiser.
// Read data is combinational so the core can sample it in its memory stage.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           uart_tx,
    output logic           tx_irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    if (BASE_ADDR[31:28] != 4'h1 || BASE_ADDR[3:0] != 4'h0) begin : g_bad_base
        $error("mmio_uart_tx: BASE_ADDR outside 0x1000_0000-0x1FFF_FFFF or misaligned");
    end

    logic          hit;
    logic [1:0]    off;
    logic          wr_hit;
    logic          enable;
    logic          overflow;
    logic [15:0]   baud_div;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    fifo_dout;
    logic [LW-1:0] level;
    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_end;
    logic          busy;
    logic [31:0]   status;
    logic          unused;

    assign unused = ^{bus.addr[1:0], bus.wr_data[31:16]};

    assign hit    = bus.cs & (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign off    = bus.addr[3:2];
    assign wr_hit = bus.wr & hit;
    assign push   = wr_hit & (off == OFF_TXDATA);

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.wr_data[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // A set in the same cycle as a write-1-clear must win.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            overflow <= 1'b0;
            baud_div <= DEFAULT_DIV;
        end else begin
            if (wr_hit && off == OFF_CTRL) enable <= bus.wr_data[CTRL_EN];
            if (wr_hit && off == OFF_BAUDDIV) baud_div <= bus.wr_data[15:0];
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end else if (wr_hit && off == OFF_CTRL && bus.wr_data[CTRL_CLR]) begin
                overflow <= 1'b0;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign tx_irq  = enable & empty & ~busy;
    assign bit_end = (bit_cnt == 16'd0);

    always_comb begin
        status = '0;
        status[ST_BUSY]        = busy;
        status[ST_FULL]        = full;
        status[ST_EMPTY]       = empty;
        status[ST_OVF]         = overflow;
        status[ST_LEVEL +: 4]  = 4'(level);
    end

    always_comb begin
        bus.rd_data = '0;
        if (hit & bus.rd) begin
            unique case (off)
                OFF_TXDATA:  bus.rd_data = '0;
                OFF_STATUS:  bus.rd_data = status;
                OFF_CTRL:    bus.rd_data = {31'd0, enable};
                OFF_BAUDDIV: bus.rd_data = {16'd0, baud_div};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        uart_tx   = 1'b1;
        unique case (state)
            IDLE: begin
                if (enable & ~empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                uart_tx = shift[bit_idx];
                if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (enable & ~empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    // Divisor is re-read at every bit boundary, so edits apply to the next bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (pop) begin
            shift   <= fifo_dout;
            bit_cnt <= baud_div;
            bit_idx <= '0;
        end else if (busy) begin
            if (bit_end) begin
                bit_cnt <= baud_div;
                if (state == DATA) bit_idx <= bit_idx + 1'b1;
            end else begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

endmodule
